// File: rtl/vdp_feeder_kcc.sv
// Sequencer for the K-cycle serial MAC: holds the G/E vectors, clears the MAC,
// streams one element pair per cycle, waits out the MAC latency and captures the sum.
module vdp_feeder_kcc #(
   parameter int N   = 8,
   parameter int K   = 3,
   parameter int L   = 2*(N-1)+K,
   parameter int LAT = 1,
   localparam int AW = (K > 1) ? $clog2(K) : 1,
   localparam int DW = (LAT > 1) ? $clog2(LAT) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic                wr_sel,
   input  logic [AW-1:0]       wr_addr,
   input  logic signed [N-1:0] wr_data,
   input  logic                start,
   output logic                busy,
   output logic                mac_rst,
   output logic signed [N-1:0] g_out,
   output logic signed [N-1:0] e_out,
   input  logic signed [L-1:0] mac_o,
   output logic                done,
   output logic signed [L-1:0] result
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [AW-1:0]       r_idx;
   logic [DW-1:0]       r_dcnt;
   logic signed [N-1:0] r_g [K];
   logic signed [N-1:0] r_e [K];
   logic                r_busy;
   logic                r_mac_rst;
   logic signed [N-1:0] r_g_out;
   logic signed [N-1:0] r_e_out;
   logic                r_done;
   logic signed [L-1:0] r_result;

   logic w_addr_ok;
   assign w_addr_ok = (32'(wr_addr) < 32'(K));

   assign busy    = r_busy;
   assign mac_rst = r_mac_rst;
   assign g_out   = r_g_out;
   assign e_out   = r_e_out;
   assign done    = r_done;
   assign result  = r_result;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_dcnt    <= '0;
         r_busy    <= 1'b0;
         r_mac_rst <= 1'b1;
         r_g_out   <= '0;
         r_e_out   <= '0;
         r_done    <= 1'b0;
         r_result  <= '0;
         for (int i = 0; i < K; i++) begin
            r_g[i] <= '0;
            r_e[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_busy    <= 1'b0;
               r_mac_rst <= 1'b1;
               r_g_out   <= '0;
               r_e_out   <= '0;
               if (wr_en && w_addr_ok) begin
                  if (wr_sel) r_e[wr_addr] <= wr_data;
                  else        r_g[wr_addr] <= wr_data;
               end
               if (start) begin
                  r_state <= S_CLEAR;
                  r_busy  <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_state   <= S_STREAM;
               r_idx     <= '0;
               r_mac_rst <= 1'b0;
               r_g_out   <= r_g[0];
               r_e_out   <= r_e[0];
            end
            S_STREAM: begin
               if (r_idx == AW'(K-1)) begin
                  r_g_out <= '0;
                  r_e_out <= '0;
                  if (LAT > 0) begin
                     r_state <= S_DRAIN;
                     r_dcnt  <= '0;
                  end else begin
                     // Zero-latency MAC: its output already holds the full sum.
                     r_state   <= S_DONE;
                     r_result  <= mac_o;
                     r_done    <= 1'b1;
                     r_busy    <= 1'b0;
                     r_mac_rst <= 1'b1;
                  end
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_g_out <= r_g[r_idx + 1'b1];
                  r_e_out <= r_e[r_idx + 1'b1];
               end
            end
            S_DRAIN: begin
               if (r_dcnt == DW'(LAT-1)) begin
                  r_state   <= S_DONE;
                  r_result  <= mac_o;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_mac_rst <= 1'b1;
               end else begin
                  r_dcnt <= r_dcnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_mac_rst <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vdp_feeder_kcc.sv
// Bench for vdp_feeder_kcc with a behavioural serial MAC attached to its outputs.
module tb_vdp_feeder_kcc;

   localparam int N   = 8;
   localparam int K   = 3;
   localparam int L   = 2*(N-1)+K;
   localparam int LAT = 1;
   localparam int AW  = (K > 1) ? $clog2(K) : 1;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                wr_en = 1'b0;
   logic                wr_sel = 1'b0;
   logic [AW-1:0]       wr_addr = '0;
   logic signed [N-1:0] wr_data = '0;
   logic                start = 1'b0;
   logic                busy;
   logic                mac_rst;
   logic signed [N-1:0] g_out;
   logic signed [N-1:0] e_out;
   logic signed [L-1:0] mac_o;
   logic                done;
   logic signed [L-1:0] result;

   int checks = 0;
   int failures = 0;

   logic signed [N-1:0] mg [K];
   logic signed [N-1:0] me [K];
   logic signed [L-1:0] acc = '0;

   always #5 clk = ~clk;

   // Behavioural MAC: one registered multiply-accumulate per cycle.
   always @(posedge clk) begin
      acc <= mac_rst ? '0 : acc + L'(int'(g_out) * int'(e_out));
   end
   assign mac_o = acc;

   vdp_feeder_kcc #(.N(N), .K(K), .L(L), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .busy(busy), .mac_rst(mac_rst),
      .g_out(g_out), .e_out(e_out), .mac_o(mac_o), .done(done), .result(result)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic sel, input int addr, input logic signed [N-1:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = AW'(addr);
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   function automatic logic signed [L-1:0] dot();
      int s = 0;
      for (int i = 0; i < K; i++) s += int'(mg[i]) * int'(me[i]);
      return L'(s);
   endfunction

   task automatic run(input bit do_load);
      logic signed [L-1:0] exp_res;
      if (do_load) begin
         for (int i = 0; i < K; i++) begin
            write(1'b0, i, mg[i]);
            write(1'b1, i, me[i]);
         end
      end
      exp_res = dot();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("clear_busy", 64'(busy), 64'(1));
      check("clear_macrst", 64'(mac_rst), 64'(1));
      for (int i = 0; i < K; i++) begin
         tick();
         check($sformatf("stream_g%0d", i), 64'(g_out), 64'(mg[i]));
         check($sformatf("stream_e%0d", i), 64'(e_out), 64'(me[i]));
         check("stream_macrst", 64'(mac_rst), 64'(0));
         check("stream_done", 64'(done), 64'(0));
      end
      for (int d = 0; d < LAT; d++) begin
         tick();
         check("drain_g", 64'(g_out), 64'(0));
         check("drain_done", 64'(done), 64'(0));
      end
      tick();
      check("done_pulse", 64'(done), 64'(1));
      check("result", 64'(result), 64'(exp_res));
      check("done_busy", 64'(busy), 64'(0));
      check("done_macrst", 64'(mac_rst), 64'(1));
      tick();
      check("done_cleared", 64'(done), 64'(0));
      check("result_held", 64'(result), 64'(exp_res));
   endtask

   task automatic load_t1();
      mg[0] = 8'sd29;  mg[1] = 8'sd74;  mg[2] = -8'sd39;
      me[0] = -8'sd38; me[1] = -8'sd91; me[2] = 8'sd47;
   endtask

   initial begin
      int dcount;
      for (int i = 0; i < K; i++) begin mg[i] = '0; me[i] = '0; end

      // Reset held for several cycles
      rst = 1'b0;
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_macrst", 64'(mac_rst), 64'(1));
      check("rst_done", 64'(done), 64'(0));
      check("rst_result", 64'(result), 64'(0));
      check("rst_g", 64'(g_out), 64'(0));
      check("rst_e", 64'(e_out), 64'(0));
      rst = 1'b1;
      tick();
      check("idle_busy", 64'(busy), 64'(0));

      // Directed vectors, then back-to-back rerun
      load_t1();
      run(1'b1);
      check("t1_value", 64'(result), 64'(-64'sd9669));
      run(1'b0);

      // Worst-case positive sum
      for (int i = 0; i < K; i++) begin mg[i] = -8'sd128; me[i] = -8'sd128; end
      run(1'b1);
      check("maxpos_value", 64'(result), 64'(64'sd49152));

      // start held during a run plus a write attempt mid-run
      load_t1();
      for (int i = 0; i < K; i++) begin
         write(1'b0, i, mg[i]);
         write(1'b1, i, me[i]);
      end
      dcount = 0;
      start = 1'b1;
      tick();
      for (int c = 1; c <= K+LAT+1; c++) begin
         if (c == 2) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'sd5;
         end
         tick();
         wr_en = 1'b0;
         dcount += int'(done);
         if (done) check("hold_result", 64'(result), 64'(dot()));
      end
      start = 1'b0;
      tick();
      dcount += int'(done);
      tick();
      dcount += int'(done);
      check("hold_one_done", 64'(dcount), 64'(1));
      check("hold_idle", 64'(busy), 64'(0));
      run(1'b0);

      // Reset during STREAM with idx=1
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("mid_idx1_g", 64'(g_out), 64'(mg[1]));
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_macrst", 64'(mac_rst), 64'(1));
      check("midrst_result", 64'(result), 64'(0));
      check("midrst_g", 64'(g_out), 64'(0));
      for (int i = 0; i < K; i++) begin mg[i] = '0; me[i] = '0; end
      tick();
      run(1'b0);

      // Out-of-range address is ignored
      for (int i = 0; i < K; i++) begin mg[i] = 8'sd1; me[i] = 8'sd1; end
      for (int i = 0; i < K; i++) begin
         write(1'b0, i, mg[i]);
         write(1'b1, i, me[i]);
      end
      write(1'b0, 3, 8'sd7);
      write(1'b1, 3, 8'sd7);
      run(1'b0);
      check("oor_value", 64'(result), 64'(3));

      // Randomised vectors
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < K; i++) begin
            mg[i] = N'($urandom);
            me[i] = N'($urandom);
         end
         run(1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vdp_feeder_kcc.md
Name: vdp_feeder_kcc

Overview:
Upstream sequencer for the K-cycle serial MAC (mac_nnbit_kcc) in the vdp benchmark.
- Holds one K-element G vector and one K-element E vector, written element by element.
- On start, clears the MAC, streams one signed (G[i], E[i]) pair per cycle, waits for the MAC's output latency, then captures the finished dot product.
- Replaces hand-sequenced testbench drive, so back-to-back dot products run without a global reset.

Parameters:
N, 8, signed element bit-width
K, 3, vector dimension (K >= 1)
L, 2*(N-1)+K, accumulator/result width; must match the MAC's output width
LAT, 1, cycles from the cycle the last pair is on g_out/e_out to the cycle mac_o holds the final sum (LAT >= 0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
wr_en  in  1  element write strobe
wr_sel  in  1  0 = write G bank, 1 = write E bank
wr_addr  in  $clog2(K) (min 1)  element index
wr_data  in  N  signed element value
start  in  1  request one dot-product run
busy  out  1  high from the cycle after start is accepted until done is asserted
mac_rst  out  1  active-high clear to the MAC's rst
g_out  out  N  signed element to the MAC's g_input
e_out  out  N  signed element to the MAC's e_input
mac_o  in  L  running MAC output
done  out  1  one-cycle pulse: result updated
result  out  L  captured signed dot product; held until the next done

Behaviour:
- All outputs are registered.
- Reset (rst=0 at an edge, including mid-run):
  - state=IDLE; both banks cleared to 0; result=0; done=0; busy=0; mac_rst=1; g_out=e_out=0.
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - busy=0, mac_rst=1, g_out=e_out=0.
  - wr_en writes wr_data into the selected bank at wr_addr.
  - wr_addr >= K: the write is ignored.
  - start=1 -> CLEAR. If wr_en and start occur in the same cycle, the write lands first and the run uses the new value.
- CLEAR: one cycle; mac_rst=1, g_out=e_out=0, busy=1 -> STREAM, idx=0.
- STREAM: K cycles.
  - mac_rst=0, g_out=G[idx], e_out=E[idx], idx++.
  - After the cycle with idx=K-1: go to DRAIN if LAT>0, else capture immediately.
- DRAIN: LAT cycles; mac_rst=0, g_out=e_out=0 (zero products leave the sum unchanged).
- Capture: at the edge ending cycle t0+LAT (t0 = last STREAM cycle), result<=mac_o and done<=1; state -> DONE.
- DONE: done=1 for exactly this cycle, busy=0, mac_rst=1 -> IDLE.
- Latency: start sampled at edge e0 -> done high in cycle e0+K+LAT+2.
  - K=3, LAT=1: done is seen 6 cycles after start.
- start while busy or in DONE: ignored, not queued. start in the cycle after done starts a new run.
- wr_en while not IDLE: ignored; the banks are stable for the whole run.
- Arithmetic: no internal math beyond the counters; result is mac_o bit-exact.
  - Sign and width are the MAC's. L = 2(N-1)+K guarantees no overflow for K products of N-bit signed values.
- Reset held low for several cycles: outputs stay at reset values. The first cycle after release is IDLE.

Test Plan:
- Load G={29,74,-39}, E={-38,-91,47} (N=8, K=3, LAT=1, behavioural MAC: acc<=mac_rst?0:acc+g*e), pulse start -> g_out/e_out show 0x1D/0xDA, 0x4A/0xA5, 0xD9/0x2F on consecutive STREAM cycles; done 6 cycles after start; result=-9669 (0x1DA3B).
- Same vectors, start asserted again the cycle after done -> mac_rst high for DONE and CLEAR; second result=0x1DA3B, with no carry-over from run 1.
- G={-128,-128,-128}, E={-128,-128,-128} -> result=49152 (0x0C000); worst-case positive value, no wrap.
- start pulsed on every cycle of a run, plus wr_en to G[0]=5 mid-run -> only one done; result unchanged by the ignored write; G[0] still 29 on the next run.
- rst=0 during STREAM (idx=1) -> next cycle busy=0, mac_rst=1, result=0, banks zero; a subsequent start yields result=0.
- wr_addr=3 (out of range) with wr_data=7, then a run with G={1,1,1}, E={1,1,1} -> result=3, and no other bank entry changed.
